// File: rtl/lc3_decode_pkg.sv
// Shared types and encodings for the LC-3 decode stage.
package lc3_decode_pkg;

  // LC-3 opcodes as carried in instr[15:12].
  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RSV  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_e;

  // alu_control encodings.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;

  // pcselect1 encodings: which offset feeds the address adder.
  localparam logic [1:0] PC1_NONE = 2'b00;
  localparam logic [1:0] PC1_OFF9 = 2'b01;
  localparam logic [1:0] PC1_OFF6 = 2'b10;
  localparam logic [1:0] PC1_ZERO = 2'b11;

  // W_Control encodings: writeback source select.
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  // Execute-stage control word, packed MSB first as seen on E_Control.
  typedef struct packed {
    logic [1:0] alu_control;
    logic [1:0] pcselect1;
    logic       pcselect2;
    logic       op2select;
  } e_control_t;

  // Opcodes this decode stage does not support.
  function automatic logic is_illegal(input opcode_e op);
    logic v;
    case (op)
      OP_JSR, OP_RTI, OP_RSV, OP_TRAP: v = 1'b1;
      default:                         v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/lc3_decode_ctrl.sv
// Combinational opcode decoder: instruction word -> execute/writeback/memory
// control words plus an illegal-opcode flag. Unused fields are driven to 0.
module lc3_decode_ctrl
  import lc3_decode_pkg::*;
(
  input  logic [15:0] i_instr,
  output logic [5:0]  o_e_control,
  output logic [1:0]  o_w_control,
  output logic        o_mem_control,
  output logic        o_illegal
);

  opcode_e    w_op;
  e_control_t w_e;
  logic [1:0] w_w;
  logic       w_m;
  logic       w_ill;
  // Only the opcode and the immediate-select bit affect decoding.
  logic       w_instr_unused;

  assign w_op           = opcode_e'(i_instr[15:12]);
  assign w_instr_unused = ^{i_instr[11:6], i_instr[4:0]};

  // Map the opcode to its control words; illegal opcodes yield all-zero controls.
  always_comb begin
    w_e   = '0;
    w_w   = WB_ALU;
    w_m   = 1'b0;
    w_ill = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_e.alu_control = ALU_ADD;
        w_e.op2select   = ~i_instr[5];
      end
      OP_AND: begin
        w_e.alu_control = ALU_AND;
        w_e.op2select   = ~i_instr[5];
      end
      OP_NOT: begin
        w_e.alu_control = ALU_NOT;
      end
      OP_BR, OP_ST: begin
        w_e.pcselect1 = PC1_OFF9;
        w_e.pcselect2 = 1'b1;
      end
      OP_LD: begin
        w_e.pcselect1 = PC1_OFF9;
        w_e.pcselect2 = 1'b1;
        w_w           = WB_MEM;
      end
      OP_LDI: begin
        w_e.pcselect1 = PC1_OFF9;
        w_e.pcselect2 = 1'b1;
        w_w           = WB_MEM;
        w_m           = 1'b1;
      end
      OP_STI: begin
        w_e.pcselect1 = PC1_OFF9;
        w_e.pcselect2 = 1'b1;
        w_m           = 1'b1;
      end
      OP_LEA: begin
        w_e.pcselect1 = PC1_OFF9;
        w_e.pcselect2 = 1'b1;
        w_w           = WB_PC;
      end
      OP_LDR: begin
        w_e.pcselect1 = PC1_OFF6;
        w_w           = WB_MEM;
      end
      OP_STR: begin
        w_e.pcselect1 = PC1_OFF6;
      end
      OP_JMP: begin
        w_e.pcselect1 = PC1_ZERO;
      end
      default: begin
        w_e   = '0;
        w_w   = WB_ALU;
        w_m   = 1'b0;
        w_ill = is_illegal(w_op);
      end
    endcase
  end

  assign o_e_control   = w_e;
  assign o_w_control   = w_w;
  assign o_mem_control = w_m;
  assign o_illegal     = w_ill;

endmodule

// File: rtl/lc3_decode.sv
// LC-3 decode stage: captures the fetched instruction and its next-PC on
// enable_decode and registers the decoded control words for later stages.
module lc3_decode
  import lc3_decode_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_decode,
  input  logic [15:0] npc_in,
  input  logic [2:0]  psr,
  input  logic [15:0] instr_dout,
  output logic [15:0] IR,
  output logic [15:0] npc_out,
  output logic [5:0]  E_Control,
  output logic [1:0]  W_Control,
  output logic        Mem_Control,
  output logic        decode_valid,
  output logic        illegal_op
);

  logic [5:0]  w_e_control;
  logic [1:0]  w_w_control;
  logic        w_mem_control;
  logic        w_illegal;
  // psr travels on the bus for the controller only.
  logic        w_psr_unused;

  logic [15:0] r_ir;
  logic [15:0] r_npc;
  logic [5:0]  r_e_control;
  logic [1:0]  r_w_control;
  logic        r_mem_control;
  logic        r_decode_valid;
  logic        r_illegal_op;

  assign w_psr_unused = ^psr;

  lc3_decode_ctrl u_ctrl (
    .i_instr       (instr_dout),
    .o_e_control   (w_e_control),
    .o_w_control   (w_w_control),
    .o_mem_control (w_mem_control),
    .o_illegal     (w_illegal)
  );

  // Capture/hold register bank; reset wins over capture, hold only drops decode_valid.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ir           <= 16'h0000;
      r_npc          <= 16'h0000;
      r_e_control    <= 6'h00;
      r_w_control    <= 2'b00;
      r_mem_control  <= 1'b0;
      r_decode_valid <= 1'b0;
      r_illegal_op   <= 1'b0;
    end else if (enable_decode) begin
      r_ir           <= instr_dout;
      r_npc          <= npc_in;
      r_e_control    <= w_e_control;
      r_w_control    <= w_w_control;
      r_mem_control  <= w_mem_control;
      r_decode_valid <= 1'b1;
      r_illegal_op   <= w_illegal;
    end else begin
      r_decode_valid <= 1'b0;
    end
  end

  assign IR           = r_ir;
  assign npc_out      = r_npc;
  assign E_Control    = r_e_control;
  assign W_Control    = r_w_control;
  assign Mem_Control  = r_mem_control;
  assign decode_valid = r_decode_valid;
  assign illegal_op   = r_illegal_op;

endmodule

// File: tb/tb_lc3_decode.sv
// Self-checking bench for lc3_decode: directed scenarios plus randomized
// traffic, compared against a table-driven reference of the decode stage.
module tb_lc3_decode;

  logic        clock;
  logic        reset;
  logic        enable_decode;
  logic [15:0] npc_in;
  logic [2:0]  psr;
  logic [15:0] instr_dout;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control;
  logic        decode_valid;
  logic        illegal_op;

  int checks   = 0;
  int failures = 0;

  lc3_decode dut (
    .clock        (clock),
    .reset        (reset),
    .enable_decode(enable_decode),
    .npc_in       (npc_in),
    .psr          (psr),
    .instr_dout   (instr_dout),
    .IR           (IR),
    .npc_out      (npc_out),
    .E_Control    (E_Control),
    .W_Control    (W_Control),
    .Mem_Control  (Mem_Control),
    .decode_valid (decode_valid),
    .illegal_op   (illegal_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference tables indexed by opcode (0..15), written from the ISA decode rules.
  int alu_tab [16] = '{0,0,0,0, 0,1,0,0, 0,2,0,0, 0,0,0,0};
  int pc1_tab [16] = '{1,0,1,1, 0,0,2,2, 0,0,1,1, 3,0,1,0};
  int pc2_tab [16] = '{1,0,1,1, 0,0,0,0, 0,0,1,1, 0,0,1,0};
  int wb_tab  [16] = '{0,0,1,0, 0,0,1,0, 0,0,1,0, 0,0,2,0};
  int mem_tab [16] = '{0,0,0,0, 0,0,0,0, 0,0,1,1, 0,0,0,0};
  int ill_tab [16] = '{0,0,0,0, 1,0,0,0, 1,0,0,0, 0,1,0,1};

  // Expected architectural state of the decode stage.
  logic [15:0] m_ir, m_npc;
  logic [5:0]  m_e;
  logic [1:0]  m_w;
  logic        m_m, m_dv, m_ill;

  logic [42:0] got, exp_v;

  function automatic logic [9:0] ref_ctrl(input logic [15:0] instr);
    int op;
    logic [5:0] e;
    logic op2;
    op  = int'(instr[15:12]);
    op2 = ((op == 1) || (op == 5)) ? ~instr[5] : 1'b0;
    e   = {alu_tab[op][1:0], pc1_tab[op][1:0], pc2_tab[op][0], op2};
    if (ill_tab[op] != 0) return {6'h00, 2'b00, 1'b0, 1'b1};
    return {e, wb_tab[op][1:0], mem_tab[op][0], 1'b0};
  endfunction

  // Drive one cycle of inputs, clock it, and advance the reference model.
  task automatic step(input logic rst_v, input logic en_v,
                      input logic [15:0] npc_v, input logic [15:0] instr_v);
    logic [9:0] c;
    reset         = rst_v;
    enable_decode = en_v;
    npc_in        = npc_v;
    instr_dout    = instr_v;
    psr           = 3'($urandom_range(0, 7));
    @(posedge clock);
    #1;
    if (!rst_v) begin
      m_ir = 16'h0; m_npc = 16'h0; m_e = 6'h0; m_w = 2'b0;
      m_m = 1'b0; m_dv = 1'b0; m_ill = 1'b0;
    end else if (en_v) begin
      c = ref_ctrl(instr_v);
      m_ir = instr_v; m_npc = npc_v;
      {m_e, m_w, m_m, m_ill} = c;
      m_dv = 1'b1;
    end else begin
      m_dv = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 16'($urandom), 16'($urandom));
      got   = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
      checks++;
      if (got !== 43'h0) begin
        failures++;
        $display("FAIL reset_state got=%h exp=%h", got, 43'h0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 16'($urandom), 16'($urandom));
      got   = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
      checks++;
      if (got !== 43'h0) begin
        failures++;
        $display("FAIL reset_hold got=%h exp=%h", got, 43'h0);
      end
    end
  endtask

  task automatic test_alu();
    logic [15:0] instrs [4] = '{16'h1283, 16'h12A5, 16'h5283, 16'h927F};
    logic [5:0]  es     [4] = '{6'h01, 6'h00, 6'h11, 6'h20};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 16'h3001 + 16'(i), instrs[i]);
      got = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
      exp_v = {instrs[i], 16'h3001 + 16'(i), es[i], 2'b00, 1'b0, 1'b1, 1'b0};
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL alu_op[%0d] got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_mem_pc();
    logic [15:0] instrs [4] = '{16'h6942, 16'hA003, 16'hE5FF, 16'hC1C0};
    logic [5:0]  es     [4] = '{6'h08, 6'h06, 6'h06, 6'h0C};
    logic [1:0]  ws     [4] = '{2'b01, 2'b01, 2'b10, 2'b00};
    logic        ms     [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 16'h4000 + 16'(i), instrs[i]);
      got = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
      exp_v = {instrs[i], 16'h4000 + 16'(i), es[i], ws[i], ms[i], 1'b1, 1'b0};
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL mem_pc_op[%0d] got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_hold();
    step(1'b1, 1'b1, 16'h5555, 16'h7A01);
    checks++;
    if ({IR, E_Control, decode_valid} !== {16'h7A01, 6'h08, 1'b1}) begin
      failures++;
      $display("FAIL hold_capture got=%h exp=%h", {IR, E_Control, decode_valid}, {16'h7A01, 6'h08, 1'b1});
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 16'h1234, 16'hFFFF);
      got = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
      exp_v = {16'h7A01, 16'h5555, 6'h08, 2'b00, 1'b0, 1'b0, 1'b0};
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL hold_freeze[%0d] got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_illegal();
    step(1'b1, 1'b1, 16'h0101, 16'hF025);
    got = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
    exp_v = {16'hF025, 16'h0101, 6'h00, 2'b00, 1'b0, 1'b1, 1'b1};
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL illegal_trap got=%h exp=%h", got, exp_v);
    end
    step(1'b1, 1'b1, 16'h0102, 16'h0E02);
    got = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
    exp_v = {16'h0E02, 16'h0102, 6'h06, 2'b00, 1'b0, 1'b1, 1'b0};
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL illegal_then_br got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_reset_priority();
    step(1'b0, 1'b1, 16'h3001, 16'h1283);
    got = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
    checks++;
    if (got !== 43'h0) begin
      failures++;
      $display("FAIL reset_priority got=%h exp=%h", got, 43'h0);
    end
    step(1'b1, 1'b1, 16'h3001, 16'h1283);
    got = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
    exp_v = {16'h1283, 16'h3001, 6'h01, 2'b00, 1'b0, 1'b1, 1'b0};
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL reset_then_capture got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_random();
    logic rst_v, en_v;
    for (int i = 0; i < 300; i++) begin
      rst_v = ($urandom_range(0, 19) != 0);
      en_v  = ($urandom_range(0, 3) != 0);
      step(rst_v, en_v, 16'($urandom), 16'($urandom));
      got   = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
      exp_v = {m_ir, m_npc, m_e, m_w, m_m, m_dv, m_ill};
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL random[%0d] got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  initial begin
    reset = 1'b0; enable_decode = 1'b0; npc_in = 16'h0; instr_dout = 16'h0; psr = 3'b0;
    m_ir = 16'h0; m_npc = 16'h0; m_e = 6'h0; m_w = 2'b0; m_m = 1'b0; m_dv = 1'b0; m_ill = 1'b0;
    test_reset();
    test_alu();
    test_mem_pc();
    test_hold();
    test_illegal();
    test_reset_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
